agc_gain_restore: RTL
=====================

AGC_GAIN_RESTORE -- requirements
Module: agc_gain_restore

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, the number of samples per sub-frame (power of two).
REQ-002 SHALL have parameter GAIN_MAX, default 16'h1400, the upper gain clamp in Q8.8 (20.0).
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clk_enable  in  1  global enable; when low, all state holds.
REQ-006 SHALL have port frame_sync  in  1  marks in_data as the first sample of a sub-frame.
REQ-007 SHALL have port in_valid  in  1  in_data is valid this cycle.
REQ-008 SHALL have port in_data  in  8  signed normalized sample.
REQ-009 SHALL have port gain_valid  in  1  gain_in is valid this cycle.
REQ-010 SHALL have port gain_in  in  16  unsigned Q8.8 gain that was applied to the next sub-frame.
REQ-011 SHALL have port out_valid  out  1  out_data is valid.
REQ-012 SHALL have port out_data  out  8  signed restored sample.
REQ-013 SHALL have port busy  out  1  reciprocal computation is in progress.
REQ-014 SHALL have port ce_out  out  1  equals clk_enable.

Function
REQ-015 SHALL clamp an accepted gain_in to the range [16'h0001, GAIN_MAX]; gain_in of 0 SHALL be treated as 16'h0100 (unity).
REQ-016 SHALL compute pending reciprocal recip = floor(2^16 / gain) as an unsigned Q8.8 value, saturated to 16'hFFFF.
REQ-017 SHALL compute recip with a sequential restoring divider producing one quotient bit per enabled cycle: 17 cycles from acceptance to done.
REQ-018 SHALL use FSM states IDLE, DIV and DONE: gain_valid moves IDLE to DIV; 17 cycles move DIV to DONE; commit moves DONE to IDLE.
REQ-019 SHALL, if gain_valid is asserted in DIV or DONE, discard the partial or pending result and restart DIV with the new gain (latest wins).
REQ-020 SHALL assert busy in DIV only.
REQ-021 SHALL count accepted samples in a log2(FRAME_LEN)-bit counter that wraps FRAME_LEN-1 to 0.
REQ-022 SHALL force the counter to 0 on an accepted sample with frame_sync=1.
REQ-023 SHALL define a frame start as an accepted sample for which the counter is 0 or frame_sync=1.
REQ-024 SHALL, on a frame start while in DONE, copy pending recip into the active recip and use it for that sample; otherwise the previous active recip is used.
REQ-025 SHALL NOT commit on a frame start that occurs while in DIV; the commit waits for the next frame start.
REQ-026 SHALL compute product = in_data × active recip as signed 8 × unsigned 16 in 25 bits, then arithmetic shift right 8.
REQ-027 SHALL saturate the shifted product to [-128, 127].
REQ-028 SHALL register out_data and out_valid with 1-cycle latency: out_valid(t+1) = in_valid(t) & clk_enable.
REQ-029 SHALL, when clk_enable=0, hold all registers including out_valid.

Reset
REQ-030 SHALL, on rst_n low, reset FSM to IDLE, counter to 0, active and pending recip to 16'h0100, out_data to 0, out_valid to 0 and busy to 0.
REQ-031 SHALL, on reset mid-DIV, abort the division; no commit occurs afterwards.

Structure
REQ-032 SHALL place Q8.8 constants (UNITY=16'h0100, GAIN_MAX default, RECIP_SAT=16'hFFFF) and the FSM state enum in a shared package agc_pkg.
REQ-033 SHALL implement the divider as sub-module agc_recip_div (start, gain, done, quotient); all other logic stays inline.

Verification
REQ-034 Scenario: after reset, in_data=64 with no gain -> out_data=64 one cycle later.
REQ-035 Scenario: gain_in=16'h0080, then frame start with in_data=40 -> out_data=80; in_data=100 -> out_data=127 (saturated).
REQ-036 Scenario: gain_in=16'h1400 -> recip=16'h000C; in_data=-128 -> out_data=-6.
REQ-037 Scenario: gain_in=0 -> recip=16'h0100; gain_in=16'h0001 -> recip=16'hFFFF; in_data=-1 -> out_data=-128.
REQ-038 Scenario: gain_valid at DIV cycle 5 with a new gain -> busy is extended by 17 cycles from restart, and only the second gain is committed.
REQ-039 Scenario: frame start during DIV -> old recip is kept for that whole frame; new recip is used from the next frame start; clk_enable low for 3 cycles -> outputs are frozen.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared Q8.8 constants and FSM state type for the AGC gain-restore block.
package agc_pkg;

    localparam logic [15:0] UNITY        = 16'h0100;
    localparam logic [15:0] GAIN_MAX_DEF = 16'h1400;
    localparam logic [15:0] RECIP_SAT    = 16'hFFFF;

    // One quotient bit per enabled cycle for a 17-bit dividend (2^16).
    localparam int unsigned DIV_STEPS = 17;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } agc_state_t;

endpackage

// File: rtl/agc_recip_div.sv
// Sequential restoring divider: quotient = floor(2^16 / gain), saturated to 16 bits.
module agc_recip_div
    import agc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        start,
    input  logic [15:0] gain,
    output logic        done,
    output logic [15:0] quotient
);

    logic [16:0] rem;
    logic [16:0] dvd;
    logic [16:0] quo;
    logic [4:0]  cnt;
    logic [15:0] divisor;

    logic [16:0] rem_sh;
    logic        fits;
    logic [16:0] rem_nx;
    logic [16:0] quo_nx;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        rem_sh = {rem[15:0], dvd[16]};
        fits   = (rem_sh >= {1'b0, divisor});
        rem_nx = fits ? (rem_sh - {1'b0, divisor}) : rem_sh;
        quo_nx = {quo[15:0], fits};
    end

    // The final step's quotient is presented combinationally so the caller can
    // capture it on the same edge that retires the last bit.
    assign done     = en && !start && (cnt == 5'd1);
    assign quotient = quo_nx[16] ? RECIP_SAT : quo_nx[15:0];

    // Divider iteration registers; start reloads and discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            dvd     <= '0;
            quo     <= '0;
            cnt     <= '0;
            divisor <= UNITY;
        end else if (en) begin
            if (start) begin
                rem     <= '0;
                dvd     <= 17'h1_0000;
                quo     <= '0;
                cnt     <= 5'(DIV_STEPS);
                divisor <= gain;
            end else if (cnt != 5'd0) begin
                rem <= rem_nx;
                dvd <= {dvd[15:0], 1'b0};
                quo <= quo_nx;
                cnt <= cnt - 5'd1;
            end
        end
    end

endmodule

// File: rtl/agc_gain_restore.sv
// Undoes the AGC gain on a sample stream by multiplying with the reciprocal gain,
// switching to a new reciprocal only on a sub-frame boundary.
module agc_gain_restore
    import agc_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 1024,
    parameter logic [15:0] GAIN_MAX  = GAIN_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_enable,
    input  logic              frame_sync,
    input  logic              in_valid,
    input  logic signed [7:0] in_data,
    input  logic              gain_valid,
    input  logic [15:0]       gain_in,
    output logic              out_valid,
    output logic signed [7:0] out_data,
    output logic              busy,
    output logic              ce_out
);

    localparam int unsigned CW = $clog2(FRAME_LEN);

    agc_state_t   state;
    logic [CW-1:0] sample_cnt;
    logic [15:0]  active_recip;
    logic [15:0]  pending_recip;

    logic         accept;
    logic         frame_start;
    logic         commit;
    logic [15:0]  use_recip;
    logic [15:0]  gain_clamped;
    logic         div_start;
    logic         div_done;
    logic [15:0]  div_quotient;

    logic signed [24:0] din_x;
    logic signed [24:0] rcp_x;
    logic signed [24:0] product;
    logic signed [24:0] shifted;
    logic signed [7:0]  sat_data;

    assign ce_out = clk_enable;

    // Sample acceptance, frame-boundary detection and reciprocal selection.
    // A new gain arriving in DONE discards the pending result, so it blocks commit.
    always_comb begin
        accept      = clk_enable && in_valid;
        frame_start = accept && ((sample_cnt == '0) || frame_sync);
        commit      = frame_start && (state == DONE) && !gain_valid;
        use_recip   = commit ? pending_recip : active_recip;
        div_start   = clk_enable && gain_valid;
        if (gain_in == 16'h0000)
            gain_clamped = UNITY;
        else if (gain_in > GAIN_MAX)
            gain_clamped = GAIN_MAX;
        else
            gain_clamped = gain_in;
    end

    // Signed sample times unsigned Q8.8 reciprocal, back to integer, saturated to 8 bits.
    always_comb begin
        din_x   = {{17{in_data[7]}}, in_data};
        rcp_x   = {9'b0, use_recip};
        product = din_x * rcp_x;
        shifted = product >>> 8;
        if (shifted > 25'sd127)
            sat_data = 8'sd127;
        else if (shifted < -25'sd128)
            sat_data = -8'sd128;
        else
            sat_data = shifted[7:0];
    end

    agc_recip_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (clk_enable),
        .start    (div_start),
        .gain     (gain_clamped),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Gain FSM: a new gain always restarts the division; results commit on a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            active_recip  <= UNITY;
            pending_recip <= UNITY;
        end else if (clk_enable) begin
            if (gain_valid) begin
                state <= DIV;
                busy  <= 1'b1;
            end else begin
                case (state)
                    DIV: begin
                        if (div_done) begin
                            state         <= DONE;
                            pending_recip <= div_quotient;
                            busy          <= 1'b0;
                        end
                    end
                    DONE: begin
                        if (commit) begin
                            state        <= IDLE;
                            active_recip <= pending_recip;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Sample counter and registered output; the frame_sync sample counts as index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (clk_enable) begin
            out_valid <= in_valid;
            if (in_valid) begin
                sample_cnt <= (frame_sync ? '0 : sample_cnt) + CW'(1);
                out_data   <= sat_data;
            end
        end
    end

endmodule
